// File: rtl/es_muldiv_unit.sv
// es_muldiv_unit: execute-stage multiply/divide unit with architectural
// HI/LO registers.
//   - MULT/MULTU commit the full product on the accept edge.
//   - MTHI/MTLO write req_src1 into HI or LO on the accept edge.
//   - DIV/DIVU run a radix-2 restoring divider, one bit per clock.
//   - Ops 110 and 111 are accepted and do nothing.
// Optional feature: define MULDIV_DIVZERO_FAST_EN to commit a divide by zero
// on the accept edge. By default a divide by zero takes the normal iteration
// path and produces the same HI/LO values.
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   req_valid/req_ready request handshake; req_ready == (state == IDLE)
//   req_op              operation code (3 bits)
//   req_src1/req_src2   rs / rt operands
//   cancel              flush; aborts a divide and blocks acceptance
//   busy                a divide is in progress
//   done                one-cycle pulse after HI/LO were committed
//   hi, lo              architectural HI/LO
module es_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_src1,
  input  logic [WIDTH-1:0] req_src2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {S_IDLE, S_DIV} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  // dvd_q holds the dividend; it shifts out MSB-first while quotient bits
  // shift in at the bottom, so it ends up holding the magnitude quotient.
  logic [WIDTH-1:0]  dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;

  logic              accept, is_div, a_neg, b_neg, div_zero_fast;
  logic [WIDTH-1:0]  a_abs, b_abs;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH:0]    rem_sh, diff;
  logic              take;
  logic [WIDTH-1:0]  rem_next, quo_next;

  assign accept = req_valid && (state_q == S_IDLE) && !cancel;
  assign is_div = (req_op == OP_DIV) || (req_op == OP_DIVU);
  assign a_neg  = (req_op == OP_DIV) && req_src1[WIDTH-1];
  assign b_neg  = (req_op == OP_DIV) && req_src2[WIDTH-1];
  assign a_abs  = a_neg ? -req_src1 : req_src1;
  assign b_abs  = b_neg ? -req_src2 : req_src2;

`ifdef MULDIV_DIVZERO_FAST_EN
  assign div_zero_fast = (req_src2 == '0);
`else
  assign div_zero_fast = 1'b0;
`endif

  // The low 2*WIDTH bits of the product of the extended operands are the
  // exact signed or unsigned product.
  assign ext_a = (req_op == OP_MULT) ? {{WIDTH{req_src1[WIDTH-1]}}, req_src1}
                                     : {{WIDTH{1'b0}}, req_src1};
  assign ext_b = (req_op == OP_MULT) ? {{WIDTH{req_src2[WIDTH-1]}}, req_src2}
                                     : {{WIDTH{1'b0}}, req_src2};
  assign prod  = ext_a * ext_b;

  // Restoring step. While the divisor is nonzero, rem_sh < 2*divisor, so a
  // WIDTH+1 bit difference is enough to read the sign. With a zero divisor
  // the subtract always succeeds. That yields an all-ones quotient and a
  // remainder equal to the dividend.
  assign rem_sh   = {rem_q, dvd_q[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, dvs_q};
  assign take     = (dvs_q == '0) || !diff[WIDTH];
  assign rem_next = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_next = {dvd_q[WIDTH-2:0], take};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (req_op)
            OP_MULT, OP_MULTU: begin
              hi_d   = prod[2*WIDTH-1:WIDTH];
              lo_d   = prod[WIDTH-1:0];
              done_d = 1'b1;
            end
            OP_MTHI: begin
              hi_d   = req_src1;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = req_src1;
              done_d = 1'b1;
            end
            default: ;
          endcase
          if (is_div) begin
            if (div_zero_fast) begin
              // The magnitude quotient is all ones, so negating it gives 1.
              // The signed remainder is the original dividend.
              lo_d   = (a_neg ^ b_neg) ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
              hi_d   = req_src1;
              done_d = 1'b1;
            end else begin
              dvd_d   = a_abs;
              dvs_d   = b_abs;
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
              rem_d   = '0;
              cnt_d   = '0;
              state_d = S_DIV;
            end
          end
        end
      end
      S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_next;
          dvd_d = quo_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
            lo_d    = qneg_q ? -quo_next : quo_next;
            hi_d    = rneg_q ? -rem_next : rem_next;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_DIV);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_es_muldiv_unit.sv
// Directed bench for es_muldiv_unit (WIDTH = 32): a table of operations with
// hand-computed HI/LO and latency, plus sequences for back-to-back moves,
// cancel, and reset in the middle of a divide.
module tb_es_muldiv_unit;
  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, cancel, busy, done;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2, hi, lo;

  always #5 clk = ~clk;

  es_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

`ifdef MULDIV_DIVZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  vec_t tbl[13];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Present one request for a single cycle. On return the bench is at the
  // falling edge just after the accept edge. The operands are then scrambled
  // so that any late sampling of them would show up.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    @(negedge clk);
    req_valid = 1'b0; req_op = 3'b111;
    req_src1 = $urandom; req_src2 = $urandom;
  endtask

  task automatic run_vec(input int i);
    int lat, low;
    issue(tbl[i].op, tbl[i].a, tbl[i].b);
    lat = 1; low = 0;
    while (!done && lat < 100) begin
      if (!req_ready) low++;
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", i), lat, tbl[i].lat);
    chk($sformatf("v%0d hi", i), hi, tbl[i].hi);
    chk($sformatf("v%0d lo", i), lo, tbl[i].lo);
    if (tbl[i].lat > 1) chk($sformatf("v%0d ready_low_cycles", i), low, tbl[i].lat - 1);
  endtask

  // Start DIVU 100/7, let wait_n more cycles pass, then raise cancel for one
  // cycle. After that, HI/LO must keep 0x11/0x22 and done must never pulse.
  task automatic cancel_test(input int wait_n, input string tag);
    int seen;
    issue(3'b011, 32'd100, 32'd7);
    repeat (wait_n) @(negedge clk);
    chk({tag, " busy_before"}, {31'b0, busy}, 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, " busy"}, {31'b0, busy}, 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk({tag, " done_count"}, seen, 32'd0);
    chk({tag, " hi"}, hi, 32'h11);
    chk({tag, " lo"}, lo, 32'h22);
  endtask

  initial begin
    int seen;
    tbl[0]  = '{3'b000, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1};
    tbl[1]  = '{3'b001, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 1};
    tbl[2]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       33};
    tbl[3]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    tbl[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 33};
    tbl[5]  = '{3'b011, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, DZ_LAT};
    tbl[6]  = '{3'b010, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'h1,        DZ_LAT};
    tbl[7]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1};
    tbl[8]  = '{3'b100, 32'hDEAD,     32'h0,        32'hDEAD,     32'hFFFFFFEB, 1};
    tbl[9]  = '{3'b101, 32'hBEEF,     32'h0,        32'hDEAD,     32'hBEEF,     1};
    tbl[10] = '{3'b011, 32'hFFFFFFFF, 32'd1,        32'h0,        32'hFFFFFFFF, 33};
    tbl[11] = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
    tbl[12] = '{3'b011, 32'h10,       32'h20,       32'h10,       32'h0,        33};

    resetn = 1'b0; req_valid = 1'b0; req_op = 3'b111; cancel = 1'b0;
    req_src1 = '0; req_src2 = '0;
    repeat (3) @(negedge clk);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset ready", {31'b0, req_ready}, 32'd1);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(i);

    // done is a single-cycle pulse.
    @(negedge clk);
    chk("done_pulse_width", {31'b0, done}, 32'd0);

    // Back-to-back moves on consecutive edges.
    req_valid = 1'b1; req_op = 3'b100; req_src1 = 32'h11;
    @(negedge clk);
    req_op = 3'b101; req_src1 = 32'h22;
    chk("b2b hi", hi, 32'h11);
    chk("b2b done1", {31'b0, done}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_op = 3'b111;
    chk("b2b lo", lo, 32'h22);
    chk("b2b done2", {31'b0, done}, 32'd1);
    @(negedge clk);
    chk("b2b done3", {31'b0, done}, 32'd0);

    // cancel must block acceptance in IDLE.
    req_valid = 1'b1; req_op = 3'b100; req_src1 = 32'h55; cancel = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; cancel = 1'b0;
    chk("idle_cancel hi", hi, 32'h11);
    chk("idle_cancel done", {31'b0, done}, 32'd0);

    cancel_test(9, "cancel_mid");
    cancel_test(31, "cancel_last");

    // Reset in the middle of a divide clears everything at once.
    issue(3'b011, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst hi", hi, 32'h0);
    chk("midrst lo", lo, 32'h0);
    chk("midrst ready", {31'b0, req_ready}, 32'd1);
    chk("midrst busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("midrst done_count", seen, 32'd0);
    chk("midrst lo_after", lo, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
